// File: rtl/ila_strip_data_check_if.sv
// Probe, trigger-control and readout bundle for the strip-data capture ILA.
// The master side feeds probes and controls; the slave side is the capture core.
interface ila_strip_data_check_if #(
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic [29:0]   probe0;
   logic [18:0]   probe1;
   logic [103:0]  probe2;
   logic [3:0]    probe3;
   logic [1:0]    probe4;
   logic [1:0]    probe5;
   logic          probe6;
   logic [103:0]  probe7;

   logic          arm;
   logic          abort;
   logic          force_trig;
   logic          trig_head_en;
   logic [3:0]    trig_head;

   logic [AW-1:0] rd_addr;
   logic [265:0]  rd_data;
   logic          busy;
   logic          triggered;
   logic          done;
   logic [AW-1:0] trig_addr;

   modport master (
      output probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7,
      output arm, abort, force_trig, trig_head_en, trig_head, rd_addr,
      input  rd_data, busy, triggered, done, trig_addr
   );

   modport slave (
      input  probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7,
      input  arm, abort, force_trig, trig_head_en, trig_head, rd_addr,
      output rd_data, busy, triggered, done, trig_addr
   );
endinterface

// File: rtl/ila_strip_data_check.sv
// Circular-buffer logic analyser for the strip-data path: PRE_TRIG samples before
// the trigger, the rest after, frozen in DONE and read back in chronological order.
module ila_strip_data_check #(
   parameter int DEPTH    = 64,
   parameter int PRE_TRIG = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ila_strip_data_check_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = 266;
   localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
   localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
   localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] cnt_reg, cnt_next;
   logic [AW-1:0] trig_addr_reg, trig_addr_next;
   logic          triggered_reg, triggered_next;
   logic [3:0]    prev_probe3_reg;
   logic [SW-1:0] rd_data_reg;
   logic          wr_en;
   logic          head_hit;
   logic          trig_hit;
   logic [SW-1:0] sample;
   logic [AW-1:0] rd_phys;

   logic [SW-1:0] mem [DEPTH];

   assign sample = {bus.probe7, bus.probe6, bus.probe5, bus.probe4,
                    bus.probe3, bus.probe2, bus.probe1, bus.probe0};

   // Header trigger fires only on the cycle probe3 changes into the target value.
   assign head_hit = bus.trig_head_en && (bus.probe3 == bus.trig_head) &&
                     (prev_probe3_reg != bus.trig_head);
   assign trig_hit = bus.force_trig || bus.probe6 || head_hit;

   // Logical index 0 is the oldest sample, PRE_TRIG entries before the trigger.
   assign rd_phys = trig_addr_reg - PRE_OFS + bus.rd_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         wr_ptr_reg      <= '0;
         cnt_reg         <= '0;
         trig_addr_reg   <= '0;
         triggered_reg   <= 1'b0;
         prev_probe3_reg <= '0;
      end else begin
         state_reg       <= state_next;
         wr_ptr_reg      <= wr_ptr_next;
         cnt_reg         <= cnt_next;
         trig_addr_reg   <= trig_addr_next;
         triggered_reg   <= triggered_next;
         prev_probe3_reg <= bus.probe3;
      end
   end

   always_comb begin
      state_next     = state_reg;
      wr_ptr_next    = wr_ptr_reg;
      cnt_next       = cnt_reg;
      trig_addr_next = trig_addr_reg;
      triggered_next = triggered_reg;
      wr_en          = 1'b0;

      if (bus.abort) begin
         state_next     = ST_IDLE;
         triggered_next = 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (bus.arm) begin
                  wr_ptr_next    = '0;
                  cnt_next       = '0;
                  triggered_next = 1'b0;
                  state_next     = ST_PRE;
               end
            end
            ST_PRE: begin
               wr_en       = 1'b1;
               wr_ptr_next = wr_ptr_reg + 1'b1;
               if (cnt_reg == PRE_LAST) begin
                  cnt_next   = '0;
                  state_next = ST_WAIT;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_WAIT: begin
               wr_en       = 1'b1;
               wr_ptr_next = wr_ptr_reg + 1'b1;
               if (trig_hit) begin
                  trig_addr_next = wr_ptr_reg;
                  triggered_next = 1'b1;
                  cnt_next       = '0;
                  state_next     = ST_POST;
               end
            end
            ST_POST: begin
               wr_en       = 1'b1;
               wr_ptr_next = wr_ptr_reg + 1'b1;
               if (cnt_reg == POST_LAST) begin
                  cnt_next   = '0;
                  state_next = ST_DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= sample;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg <= '0;
      end else begin
         rd_data_reg <= mem[rd_phys];
      end
   end

   assign bus.rd_data   = rd_data_reg;
   assign bus.busy      = (state_reg == ST_PRE) || (state_reg == ST_WAIT) ||
                          (state_reg == ST_POST);
   assign bus.done      = (state_reg == ST_DONE);
   assign bus.triggered = triggered_reg;
   assign bus.trig_addr = trig_addr_reg;
endmodule

// File: tb/tb_ila_strip_data_check.sv
// Self-checking bench for ila_strip_data_check: a history of every driven sample
// feeds a scoreboard queue of expected readout words.
module tb_ila_strip_data_check;
   localparam int DEPTH    = 64;
   localparam int PRE_TRIG = 16;
   localparam int POST_N   = DEPTH - PRE_TRIG - 1;
   localparam int HMAX     = 1024;

   logic clk;
   logic rst_n;

   ila_strip_data_check_if #(.DEPTH(DEPTH)) bus ();

   ila_strip_data_check #(
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE_TRIG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int             n_cmp;
   int             n_bad;
   int             ecount;
   bit             rnd_p3;
   logic [265:0]   hist [HMAX];
   logic [265:0]   exp_q [$];

   task automatic check(input string tag, input logic [265:0] got, input logic [265:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [265:0] cur_sample();
      return {bus.probe7, bus.probe6, bus.probe5, bus.probe4,
              bus.probe3, bus.probe2, bus.probe1, bus.probe0};
   endfunction

   task automatic rand_probes();
      logic [127:0] w;
      bus.probe0 = 30'($urandom);
      bus.probe1 = 19'($urandom);
      w = {$urandom, $urandom, $urandom, $urandom};
      bus.probe2 = w[103:0];
      w = {$urandom, $urandom, $urandom, $urandom};
      bus.probe7 = w[103:0];
      bus.probe4 = 2'($urandom_range(0, 3));
      bus.probe5 = 2'($urandom_range(0, 3));
      if (rnd_p3) bus.probe3 = 4'($urandom_range(0, 15));
   endtask

   // Edge n after the arm edge (edge 0) captures hist[n]; ecount holds the last edge.
   task automatic tick();
      ecount++;
      if (ecount >= 0 && ecount < HMAX) hist[ecount] = cur_sample();
      @(posedge clk);
      #1;
      rand_probes();
   endtask

   task automatic do_arm();
      bus.arm = 1'b1;
      ecount  = -1;
      tick();
      bus.arm = 1'b0;
   endtask

   task automatic ticks_until(input int edge_n);
      while (ecount < edge_n) tick();
   endtask

   task automatic wait_trig(input string tag, input int exp_edge);
      int n;
      n = 0;
      while (!bus.triggered && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_trig_edge"}, 266'(ecount), 266'(exp_edge));
   endtask

   task automatic finish_capture(input string tag, input int tk);
      int n;
      n = 0;
      while (!bus.done && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_done_lat"}, 266'(ecount - tk), 266'(POST_N));
      check({tag, "_busy_off"}, 266'(bus.busy), 266'(0));
      check({tag, "_trig_addr"}, 266'(bus.trig_addr), 266'((tk - 1) % DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = 6'(i);
         exp_q.push_back(hist[tk - PRE_TRIG + i]);
         tick();
         check($sformatf("%s_rd%0d", tag, i), bus.rd_data, exp_q.pop_front());
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      ecount = -1;
      rnd_p3 = 1'b1;
      rst_n  = 1'b0;
      bus.arm = 1'b0;
      bus.abort = 1'b0;
      bus.force_trig = 1'b0;
      bus.trig_head_en = 1'b0;
      bus.trig_head = 4'h0;
      bus.rd_addr = '0;
      bus.probe6 = 1'b0;
      bus.probe3 = 4'h0;
      rand_probes();

      #12;
      check("rst_busy", 266'(bus.busy), 266'(0));
      check("rst_done", 266'(bus.done), 266'(0));
      check("rst_trig", 266'(bus.triggered), 266'(0));
      check("rst_taddr", 266'(bus.trig_addr), 266'(0));
      check("rst_rdata", bus.rd_data, 266'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // probe6 held high from arm: trigger on first WAIT edge
      bus.probe6 = 1'b1;
      do_arm();
      check("t40_busy", 266'(bus.busy), 266'(1));
      wait_trig("t40", PRE_TRIG + 1);
      bus.probe6 = 1'b0;
      finish_capture("t40", PRE_TRIG + 1);

      // single probe6 pulse at edge 101; stray arm in WAIT must be ignored
      do_arm();
      ticks_until(49);
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      ticks_until(100);
      check("t39_pre_trig", 266'(bus.triggered), 266'(0));
      bus.probe6 = 1'b1;
      tick();
      bus.probe6 = 1'b0;
      check("t39_trig", 266'(bus.triggered), 266'(1));
      finish_capture("t39", 101);

      // header trigger on the first of two consecutive C nibbles
      rnd_p3 = 1'b0;
      bus.probe3 = 4'hA;
      bus.trig_head = 4'hC;
      bus.trig_head_en = 1'b1;
      do_arm();
      ticks_until(32);
      check("t41_no_trig", 266'(bus.triggered), 266'(0));
      bus.probe3 = 4'hC;
      tick();
      check("t41_trig", 266'(bus.triggered), 266'(1));
      tick();
      bus.trig_head_en = 1'b0;
      rnd_p3 = 1'b1;
      finish_capture("t41", 33);

      // long WAIT with several pointer wraps, then force_trig
      do_arm();
      ticks_until(299);
      bus.force_trig = 1'b1;
      tick();
      bus.force_trig = 1'b0;
      finish_capture("t42", 300);

      // abort in POST (with arm in the same cycle), then a normal capture
      do_arm();
      ticks_until(19);
      bus.force_trig = 1'b1;
      tick();
      bus.force_trig = 1'b0;
      ticks_until(25);
      bus.abort = 1'b1;
      bus.arm = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.arm = 1'b0;
      check("t43_busy", 266'(bus.busy), 266'(0));
      check("t43_done", 266'(bus.done), 266'(0));
      check("t43_trig", 266'(bus.triggered), 266'(0));
      do_arm();
      ticks_until(39);
      bus.probe6 = 1'b1;
      tick();
      bus.probe6 = 1'b0;
      finish_capture("t43", 40);

      // asynchronous reset pulse during WAIT
      do_arm();
      ticks_until(25);
      rst_n = 1'b0;
      #2;
      check("t44_busy", 266'(bus.busy), 266'(0));
      check("t44_trig", 266'(bus.triggered), 266'(0));
      check("t44_done", 266'(bus.done), 266'(0));
      check("t44_taddr", 266'(bus.trig_addr), 266'(0));
      check("t44_rdata", bus.rd_data, 266'(0));
      tick();
      rst_n = 1'b1;
      tick();
      check("t44_done_after", 266'(bus.done), 266'(0));
      do_arm();
      ticks_until(49);
      bus.force_trig = 1'b1;
      tick();
      bus.force_trig = 1'b0;
      finish_capture("t44", 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ila_strip_data_check.md
ILA_STRIP_DATA_CHECK -- requirements
Module: ila_strip_data_check

Interface
REQ-001 Parameter DEPTH, default 64, capture buffer depth in samples (power of two, >= 4).
REQ-002 Parameter PRE_TRIG, default 16, samples retained before trigger (1 <= PRE_TRIG <= DEPTH-2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 probe0  input  30  raw strip data word.
REQ-006 probe1  input  19  link message.
REQ-007 probe2  input  104  assembled frame.
REQ-008 probe3  input  4  previous header nibble.
REQ-009 probe4  input  2  free-running counter.
REQ-010 probe5  input  2  captured counter position.
REQ-011 probe6  input  1  frame data valid.
REQ-012 probe7  input  104  registered frame.
REQ-013 arm  input  1  single-cycle pulse starting a capture.
REQ-014 abort  input  1  return to idle.
REQ-015 force_trig  input  1  unconditional trigger.
REQ-016 trig_head_en  input  1  enable header-match trigger.
REQ-017 trig_head  input  4  header value for header-match trigger.
REQ-018 rd_addr  input  log2(DEPTH)  logical readout index, 0 = oldest sample.
REQ-019 rd_data  output  266  sample at rd_addr.
REQ-020 busy  output  1  capture in progress.
REQ-021 triggered  output  1  trigger has occurred in current capture.
REQ-022 done  output  1  capture complete, buffer frozen.
REQ-023 trig_addr  output  log2(DEPTH)  physical address of trigger sample.

Function
REQ-024 Sample vector S = {probe7,probe6,probe5,probe4,probe3,probe2,probe1,probe0}, 266 bits, probe0 in LSBs.
REQ-025 States: IDLE, PRE, WAIT, POST, DONE; busy = 1 in PRE/WAIT/POST; done = 1 only in DONE.
REQ-026 arm in IDLE or DONE: wr_ptr <= 0, triggered <= 0, -> PRE; arm in PRE/WAIT/POST ignored.
REQ-027 PRE/WAIT/POST: S written to mem[wr_ptr] each cycle; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-028 PRE lasts exactly PRE_TRIG write cycles, then -> WAIT; trigger conditions ignored in PRE.
REQ-029 Trigger in WAIT = force_trig OR probe6 = 1 OR (trig_head_en AND probe3 = trig_head AND previous-cycle probe3 != trig_head).
REQ-030 On trigger: that cycle's S written, trig_addr <= wr_ptr of that write, triggered <= 1, -> POST.
REQ-031 POST writes DEPTH-PRE_TRIG-1 further samples, then -> DONE; total stored = DEPTH, trigger sample at logical index PRE_TRIG.
REQ-032 DONE: no writes; contents held until next arm.
REQ-033 Readout: physical address = (trig_addr - PRE_TRIG + rd_addr) mod DEPTH; rd_data registered, 1-cycle latency, valid in any state.
REQ-034 abort (any state) -> IDLE next cycle, triggered <= 0, no write that cycle; abort dominates arm and trigger in same cycle.
REQ-035 Previous-cycle probe3 register updates every cycle regardless of state.

Reset
REQ-036 rst_n low: state IDLE, wr_ptr 0, trig_addr 0, triggered 0, rd_data 0, previous-probe3 0; outputs take effect immediately.
REQ-037 Memory contents are not reset.
REQ-038 Reset mid-capture abandons capture; done stays 0 until a new capture completes.

Verification
REQ-039 Arm, probe6 = 0 for 100 cycles, then probe6 = 1 for one cycle -> done exactly 47 cycles after trigger; rd_addr 16 returns trigger sample with bit 265-104 position (probe6) = 1.
REQ-040 probe6 = 1 continuously from arm -> trigger on first WAIT cycle (17th cycle after arm); rd_addr 0..15 return first 16 samples in order.
REQ-041 trig_head_en = 1, trig_head = 4'hC, probe3 sequence A,A,C,C -> trigger on first C only; trig_addr matches wr_ptr of that cycle.
REQ-042 Long WAIT (wr_ptr wraps several times), force_trig -> rd_addr 0..63 give 64 consecutive samples ending 47 cycles after trigger, chronological order.
REQ-043 abort asserted in POST -> busy 0, done 0, triggered 0 next cycle; subsequent arm restarts capture normally.
REQ-044 rst_n pulsed low in WAIT -> all outputs at reset values asynchronously; arm after release performs full capture.
